// File: rtl/secded_encoder_pkg.sv
// Shared ECC definitions for the SEC-DED (39,32) encoder and decoder.
// Holds the code geometry, the injection mode codes, the table that maps each
// data bit to its Hamming position, and a helper that builds the injection flip mask.
package secded_encoder_pkg;

  localparam int ECC_DATA_W = 32;
  localparam int ECC_HAM_W  = 6;
  localparam int ECC_PAR_W  = 7;
  localparam int ECC_CW_W   = 39;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_RSVD   = 2'b11
  } inj_mode_e;

  // data[k] sits at the k-th non-power-of-two Hamming position
  localparam logic [ECC_HAM_W-1:0] HAM_POS [ECC_DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  // Codeword bit layout: [31:0] data, [38:32] parity; double flips wrap 38 -> 0
  function automatic logic [ECC_CW_W-1:0] inj_flip_mask(input inj_mode_e mode,
                                                       input logic [5:0] idx);
    logic [ECC_CW_W-1:0] mask;
    logic [5:0]          nxt;
    mask = '0;
    nxt  = (idx == 6'(ECC_CW_W - 1)) ? 6'd0 : idx + 6'd1;
    if (mode == INJ_SINGLE || mode == INJ_DOUBLE) mask[idx] = 1'b1;
    if (mode == INJ_DOUBLE) mask[nxt] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/secded_encoder_parity_gen.sv
// Combinational 32 -> 7 SEC-DED parity function (module secded_parity_gen).
// parity[5:0] are the Hamming check bits, parity[6] is the overall parity of
// data and check bits. The function is linear, so XOR-ing the parity of two
// disjoint data slices gives the parity of the whole word.
module secded_parity_gen
  import secded_encoder_pkg::*;
(
  input  logic [ECC_DATA_W-1:0] data,
  output logic [ECC_PAR_W-1:0]  parity
);

  logic [ECC_HAM_W-1:0] ham;

  // Each check bit collects the data bits whose Hamming position has that bit set
  always_comb begin
    ham = '0;
    for (int k = 0; k < ECC_DATA_W; k++) begin
      for (int i = 0; i < ECC_HAM_W; i++) begin
        if (data[k] && HAM_POS[k][i]) ham[i] = ~ham[i];
      end
    end
    parity = {(^data) ^ (^ham), ham};
  end

endmodule

// File: rtl/secded_encoder.sv
// Two-stage pipelined SEC-DED (39,32) encoder for the memory write path.
// S1 holds the data word and the parity of its low and high halves, S2 holds
// the final codeword. Optional one-shot error injection is compiled in only
// when ECC_ERR_INJECT_EN is defined.
module secded_encoder
  import secded_encoder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [6:0]        out_parity,
  output logic [CNT_W-1:0]  word_count,
  input  logic [1:0]        inj_mode,
  input  logic [5:0]        inj_bit,
  input  logic              inj_arm,
  output logic              inj_armed
);

  localparam int HALF_W = ECC_DATA_W / 2;

  if (DATA_W != ECC_DATA_W) begin : g_bad_width
    $error("secded_encoder: only DATA_W = 32 is supported");
  end

  logic                  s1_valid;
  logic [DATA_W-1:0]     s1_data;
  logic [ECC_PAR_W-1:0]  s1_par_lo;
  logic [ECC_PAR_W-1:0]  s1_par_hi;
  logic [ECC_PAR_W-1:0]  par_lo;
  logic [ECC_PAR_W-1:0]  par_hi;
  logic                  s2_advance;
  logic                  s2_load;
  logic [ECC_CW_W-1:0]   inj_flip;

  secded_parity_gen u_par_lo (
    .data   ({{HALF_W{1'b0}}, in_data[HALF_W-1:0]}),
    .parity (par_lo)
  );

  secded_parity_gen u_par_hi (
    .data   ({in_data[DATA_W-1:HALF_W], {HALF_W{1'b0}}}),
    .parity (par_hi)
  );

  assign s2_advance = !out_valid || out_ready;
  assign s2_load    = s1_valid && s2_advance;
  assign in_ready   = !s1_valid || s2_advance;

`ifdef ECC_ERR_INJECT_EN
  inj_mode_e  inj_mode_q;
  logic [5:0] inj_bit_q;
  logic       arm_ok;

  assign arm_ok   = inj_arm && (inj_mode == INJ_SINGLE || inj_mode == INJ_DOUBLE)
                    && (inj_bit <= 6'(ECC_CW_W - 1));
  assign inj_flip = inj_armed ? inj_flip_mask(inj_mode_q, inj_bit_q) : '0;

  // A valid arm always wins; otherwise the armed state clears when S2 takes a word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inj_armed  <= 1'b0;
      inj_mode_q <= INJ_NONE;
      inj_bit_q  <= '0;
    end else if (arm_ok) begin
      inj_armed  <= 1'b1;
      inj_mode_q <= inj_mode_e'(inj_mode);
      inj_bit_q  <= inj_bit;
    end else if (s2_load && inj_armed) begin
      inj_armed  <= 1'b0;
    end
  end
`else
  logic unused_inj;

  assign unused_inj = ^{inj_mode, inj_bit, inj_arm};
  assign inj_flip   = '0;
  assign inj_armed  = 1'b0;
`endif

  // Advance S1/S2 under the valid/ready handshake and count delivered codewords
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= '0;
      word_count <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data   <= in_data;
          s1_par_lo <= par_lo;
          s1_par_hi <= par_hi;
        end
      end
      if (s2_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data   <= s1_data ^ inj_flip[DATA_W-1:0];
          out_parity <= s1_par_lo ^ s1_par_hi ^ inj_flip[ECC_CW_W-1:DATA_W];
        end
      end
      if (out_valid && out_ready && (word_count != {CNT_W{1'b1}})) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

endmodule
